// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD down-timer slice.
// Digit width, BCD limit, FSM states and a digit validity helper.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-count chain.
// A borrow into a 0 digit yields 9 and passes the borrow on.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] d_in,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] d_out,
    output logic             borrow_out
);

    // Decrement this digit when borrowed from, wrapping 0 to 9
    always_comb begin
        d_out      = d_in;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (d_in == '0) begin
                d_out      = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                d_out = d_in - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with load, start, pause and tick.
// Define BCD_DOWN_AUTORELOAD_EN to reload the preset on reaching zero.
module bcd_down_timer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst_asyn,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    tick,
    output logic [BCD_W*DIGITS-1:0] Q_out,
    output logic                    running,
    output logic                    done,
    output logic                    zero,
    output logic                    err
);

    localparam int W = BCD_W * DIGITS;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_q;
    logic [W-1:0] r_reload;
    state_t       r_state;
    logic         r_running;
    logic         r_done;
    logic         r_zero;
    logic         r_err;

    logic [W-1:0]      w_dec;
    logic [DIGITS:0]   w_borrow;
    logic [DIGITS-1:0] w_dig_ok;
    logic              w_load_ok;
    logic              w_q_zero;
    logic              w_q_is_one;

    logic [W-1:0] w_q_nxt;
    logic [W-1:0] w_reload_nxt;
    state_t       w_state_nxt;
    logic         w_done_nxt;
    logic         w_err_nxt;

    assign w_borrow[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_down_digit u_dig (
            .d_in      (r_q[g*BCD_W +: BCD_W]),
            .borrow_in (w_borrow[g]),
            .d_out     (w_dec[g*BCD_W +: BCD_W]),
            .borrow_out(w_borrow[g+1])
        );
        assign w_dig_ok[g] = is_bcd(load_val[g*BCD_W +: BCD_W]);
    end

    assign w_load_ok  = &w_dig_ok;
    // A borrow out of the top digit means every digit was already 0
    assign w_q_zero   = w_borrow[DIGITS];
    assign w_q_is_one = (r_q == ONE);

`ifndef BCD_DOWN_AUTORELOAD_EN
    // The reload value only feeds the autoreload path
    logic w_unused_reload;
    assign w_unused_reload = ^r_reload;
`endif

    // State, count and flag registers
    always_ff @(posedge clk or posedge rst_asyn) begin
        if (rst_asyn) begin
            r_q       <= '0;
            r_reload  <= '0;
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_zero    <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            r_q       <= w_q_nxt;
            r_reload  <= w_reload_nxt;
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == RUN);
            r_done    <= w_done_nxt;
            r_zero    <= (w_q_nxt == '0);
            r_err     <= w_err_nxt;
        end
    end

    // Next state with priority load > pause > start > tick
    always_comb begin
        w_q_nxt      = r_q;
        w_reload_nxt = r_reload;
        w_state_nxt  = r_state;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;
        if (load) begin
            if (w_load_ok) begin
                w_q_nxt      = load_val;
                w_reload_nxt = load_val;
                w_err_nxt    = 1'b0;
                w_state_nxt  = IDLE;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (pause) begin
            if (r_state == RUN) begin
                w_state_nxt = PAUSED;
            end
        end else if (start) begin
            case (r_state)
                IDLE: begin
                    if (!w_q_zero) begin
                        w_state_nxt = RUN;
                    end
                end
                PAUSED:  w_state_nxt = RUN;
                default: w_state_nxt = r_state;
            endcase
        end else if (tick && (r_state == RUN) && !w_q_zero) begin
            w_q_nxt = w_dec;
            if (w_q_is_one) begin
                w_done_nxt = 1'b1;
`ifdef BCD_DOWN_AUTORELOAD_EN
                if (r_reload != '0) begin
                    w_q_nxt     = r_reload;
                    w_state_nxt = RUN;
                end else begin
                    w_q_nxt     = '0;
                    w_state_nxt = DONE;
                end
`else
                w_q_nxt     = '0;
                w_state_nxt = DONE;
`endif
            end
        end
    end

    assign Q_out   = r_q;
    assign running = r_running;
    assign done    = r_done;
    assign zero    = r_zero;
    assign err     = r_err;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Randomized bench for bcd_down_timer (DIGITS=2) against an integer model.
// Directed cases pin the model with literal expectations.
module tb_bcd_down_timer;

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSED = 2;
    localparam int S_DONE   = 3;

    logic       clk;
    logic       rst_asyn;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic       tick;
    logic [7:0] Q_out;
    logic       running;
    logic       done;
    logic       zero;
    logic       err;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    int m_val;
    int m_rel;
    int m_st;
    bit m_done;
    bit m_err;

    bcd_down_timer #(.DIGITS(2)) dut (
        .clk     (clk),
        .rst_asyn(rst_asyn),
        .load    (load),
        .load_val(load_val),
        .start   (start),
        .pause   (pause),
        .tick    (tick),
        .Q_out   (Q_out),
        .running (running),
        .done    (done),
        .zero    (zero),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Behavioural model: integer count value and a coarse mode
    always @(posedge clk or posedge rst_asyn) begin
        if (rst_asyn) begin
            m_val  = 0;
            m_rel  = 0;
            m_st   = S_IDLE;
            m_done = 0;
            m_err  = 0;
        end else begin
            m_done = 0;
            if (load) begin
                if (load_val[7:4] <= 9 && load_val[3:0] <= 9) begin
                    m_val = 10 * int'(load_val[7:4]) + int'(load_val[3:0]);
                    m_rel = m_val;
                    m_err = 0;
                    m_st  = S_IDLE;
                end else begin
                    m_err = 1;
                end
            end else if (pause) begin
                if (m_st == S_RUN) m_st = S_PAUSED;
            end else if (start) begin
                if ((m_st == S_IDLE && m_val != 0) || m_st == S_PAUSED)
                    m_st = S_RUN;
            end else if (tick && m_st == S_RUN) begin
                m_val = m_val - 1;
                if (m_val == 0) begin
                    m_done = 1;
`ifdef BCD_DOWN_AUTORELOAD_EN
                    if (m_rel != 0) m_val = m_rel;
                    else m_st = S_DONE;
`else
                    m_st = S_DONE;
`endif
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_q", Q_out, to_bcd(m_val));
            chk("model_running", running, (m_st == S_RUN));
            chk("model_done", done, m_done);
            chk("model_zero", zero, (m_val == 0));
            chk("model_err", err, m_err);
        end
    end

    task automatic step(input logic l, input logic [7:0] v,
                        input logic s, input logic p, input logic t);
        load     = l;
        load_val = v;
        start    = s;
        pause    = p;
        tick     = t;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_seq [21] = '{
        8'h20, 8'h19, 8'h18, 8'h17, 8'h16, 8'h15, 8'h14,
        8'h13, 8'h12, 8'h11, 8'h10, 8'h09, 8'h08, 8'h07,
        8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00
    };

    initial begin
        rst_asyn = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;
        start    = 1'b0;
        pause    = 1'b0;
        tick     = 1'b0;
        #8;
        chk("rst_q", Q_out, 8'h00);
        chk("rst_zero", zero, 1'b1);
        chk("rst_running", running, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        #4 rst_asyn = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1;

        // Borrow chain 21 down to 00
        step(1, 8'h21, 0, 0, 0);
        chk("chain_load", Q_out, 8'h21);
        step(0, 8'h00, 1, 0, 0);
        chk("chain_run", running, 1'b1);
        for (int i = 0; i < 21; i++) begin
            step(0, 8'h00, 0, 0, 1);
            chk("chain_q", Q_out, exp_seq[i]);
            chk("chain_done", done, (i == 20));
        end
        chk("chain_zero", zero, 1'b1);
        step(0, 8'h00, 0, 0, 0);
        chk("done_hold_q", Q_out, 8'h00);
        chk("done_pulse_end", done, 1'b0);
        step(0, 8'h00, 1, 0, 1);
        chk("done_start_ign", running, 1'b0);

        // Pause and tick in the same cycle
        step(1, 8'h15, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 1, 1);
        chk("pause_q", Q_out, 8'h15);
        chk("pause_running", running, 1'b0);
        step(0, 8'h00, 0, 0, 1);
        chk("paused_tick_ign", Q_out, 8'h15);
        step(0, 8'h00, 1, 0, 0);
        chk("resume_running", running, 1'b1);
        step(0, 8'h00, 0, 0, 1);
        chk("resume_tick", Q_out, 8'h14);

        // Invalid then valid load
        step(1, 8'h42, 0, 0, 0);
        step(1, 8'h3A, 0, 0, 0);
        chk("bad_load_q", Q_out, 8'h42);
        chk("bad_load_err", err, 1'b1);
        step(1, 8'h05, 0, 0, 0);
        chk("good_load_q", Q_out, 8'h05);
        chk("good_load_err", err, 1'b0);

        // Start with a zero count
        step(1, 8'h00, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        chk("zstart_running", running, 1'b0);
        chk("zstart_done", done, 1'b0);
        chk("zstart_zero", zero, 1'b1);

        // Asynchronous reset while running at 37
        step(1, 8'h37, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        #2 rst_asyn = 1'b1;
        #1;
        chk("arst_q", Q_out, 8'h00);
        chk("arst_zero", zero, 1'b1);
        chk("arst_running", running, 1'b0);
        #1 rst_asyn = 1'b0;

`ifdef BCD_DOWN_AUTORELOAD_EN
        step(1, 8'h03, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        chk("ar_q2", Q_out, 8'h02);
        step(0, 8'h00, 0, 0, 1);
        chk("ar_q1", Q_out, 8'h01);
        step(0, 8'h00, 0, 0, 1);
        chk("ar_reload", Q_out, 8'h03);
        chk("ar_done", done, 1'b1);
        chk("ar_running", running, 1'b1);
`endif

        // Randomized traffic checked by the model each cycle
        for (int n = 0; n < 3000; n++) begin
            logic       l;
            logic [7:0] v;
            logic       s;
            logic       p;
            logic       t;
            l = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0) begin
                v = 8'($urandom());
            end else begin
                v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            s = ($urandom_range(0, 99) < 12);
            p = ($urandom_range(0, 99) < 6);
            t = ($urandom_range(0, 99) < 65);
            step(l, v, s, p, t);
            if ($urandom_range(0, 599) == 0) begin
                #1 rst_asyn = 1'b1;
                #1 rst_asyn = 1'b0;
            end
        end

        step(0, 8'h00, 0, 0, 0);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
